// File: rtl/instr_decode_stage.sv
// -----------------------------------------------------------------------------
// instr_decode_stage
//
// Registered, flow-controlled instruction decode stage. It accepts 32-bit
// instruction words on a valid/ready handshake and decodes them combinationally.
// The decoded bundle is kept in a 2-entry FIFO made of a main entry and a skid
// entry. The stage also tracks the most recently emitted lw, and either flags
// a dependent instruction or stalls it for one bubble.
//
// Parameters
//   ID_W          width of o_out_id (>= 6)
//   IMM_W         width of o_out_imm (>= 26)
//   HAZARD_STALL  1: one bubble on load-use, 0: flag only
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_flush             synchronous flush of both entries and hazard state
//   i_in_valid          upstream instruction valid
//   o_in_ready          stage can accept (skid entry empty)
//   i_in_ir             instruction word
//   o_out_valid         decoded instruction presented
//   i_out_ready         downstream accepts
//   o_out_id            opcode of a legal instruction, 0 if illegal
//   o_out_rs/rt/rd      raw register fields
//   o_out_dst           destination register index
//   o_out_dst_valid     instruction writes o_out_dst
//   o_out_src1_valid    rs is read
//   o_out_src2_valid    rt is read
//   o_out_imm           extended immediate or jump target
//   o_out_illegal       opcode not in the legal set
//   o_out_load_use      instruction depends on the immediately preceding lw
// -----------------------------------------------------------------------------
module instr_decode_stage #(
   parameter int unsigned ID_W         = 6,
   parameter int unsigned IMM_W        = 32,
   parameter bit          HAZARD_STALL = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [31:0]      i_in_ir,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [ID_W-1:0]  o_out_id,
   output logic [4:0]       o_out_rs,
   output logic [4:0]       o_out_rt,
   output logic [4:0]       o_out_rd,
   output logic [4:0]       o_out_dst,
   output logic             o_out_dst_valid,
   output logic             o_out_src1_valid,
   output logic             o_out_src2_valid,
   output logic [IMM_W-1:0] o_out_imm,
   output logic             o_out_illegal,
   output logic             o_out_load_use
);

   localparam logic [5:0] OP_ADD  = 6'd0;
   localparam logic [5:0] OP_ADDI = 6'd1;
   localparam logic [5:0] OP_AND  = 6'd3;
   localparam logic [5:0] OP_ORI  = 6'd6;
   localparam logic [5:0] OP_LW   = 6'd8;
   localparam logic [5:0] OP_SW   = 6'd9;
   localparam logic [5:0] OP_J    = 6'd16;
   localparam logic [5:0] OP_SLT  = 6'd19;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [4:0]       rs;
      logic [4:0]       rt;
      logic [4:0]       rd;
      logic [4:0]       dst;
      logic             dst_valid;
      logic             src1_valid;
      logic             src2_valid;
      logic [IMM_W-1:0] imm;
      logic             illegal;
      logic             is_lw;
      logic             load_use;   // sticky: this entry already took its bubble
   } entry_t;

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} buf_state_e;

   buf_state_e r_state;
   buf_state_e w_state_d;
   entry_t     r_main;
   entry_t     r_skid;
   entry_t     w_dec;
   logic       r_ld_valid;
   logic [4:0] r_ld_dst;
   logic       w_main_v;
   logic       w_hit;
   logic       w_bubble;
   logic       w_accept;
   logic       w_drain;

   // ---------------------------------------------------------------------------
   // Combinational decode of the incoming word
   // ---------------------------------------------------------------------------
   always_comb begin
      logic [5:0]       w_op;
      logic [IMM_W-1:0] w_sext;
      logic [IMM_W-1:0] w_zext;
      logic [IMM_W-1:0] w_tgt;

      w_op   = i_in_ir[31:26];
      w_sext = {IMM_W{i_in_ir[15]}};
      w_sext[15:0] = i_in_ir[15:0];
      w_zext = '0;
      w_zext[15:0] = i_in_ir[15:0];
      w_tgt  = '0;
      w_tgt[25:0] = i_in_ir[25:0];

      w_dec    = '0;
      w_dec.rs = i_in_ir[25:21];
      w_dec.rt = i_in_ir[20:16];
      w_dec.rd = i_in_ir[15:11];

      case (w_op)
         OP_ADD, OP_AND, OP_SLT: begin
            w_dec.dst        = i_in_ir[15:11];
            w_dec.dst_valid  = 1'b1;
            w_dec.src1_valid = 1'b1;
            w_dec.src2_valid = 1'b1;
         end
         OP_ADDI, OP_LW: begin
            w_dec.dst        = i_in_ir[20:16];
            w_dec.dst_valid  = 1'b1;
            w_dec.src1_valid = 1'b1;
            w_dec.imm        = w_sext;
            w_dec.is_lw      = (w_op == OP_LW);
         end
         OP_ORI: begin
            w_dec.dst        = i_in_ir[20:16];
            w_dec.dst_valid  = 1'b1;
            w_dec.src1_valid = 1'b1;
            w_dec.imm        = w_zext;
         end
         OP_SW: begin
            w_dec.src1_valid = 1'b1;
            w_dec.src2_valid = 1'b1;
            w_dec.imm        = w_sext;
         end
         OP_J: begin
            w_dec.imm = w_tgt;
         end
         default: begin
            w_dec.illegal = 1'b1;
         end
      endcase

      if (!w_dec.illegal) begin
         w_dec.id[5:0] = w_op;
      end
      // Writes to r0 are architecturally discarded.
      if (w_dec.dst == 5'd0) begin
         w_dec.dst_valid = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Hazard detection against the last emitted lw
   // ---------------------------------------------------------------------------
   assign w_hit = r_ld_valid && w_main_v &&
                  ((r_main.src1_valid && (r_main.rs == r_ld_dst)) ||
                   (r_main.src2_valid && (r_main.rt == r_ld_dst)));
   assign w_bubble = HAZARD_STALL && w_hit;
   assign w_accept = i_in_valid && o_in_ready && !i_flush;
   assign w_drain  = o_out_valid && i_out_ready;

   // ---------------------------------------------------------------------------
   // Buffer FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StEmpty;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Buffer FSM: next state
   always_comb begin
      w_state_d = r_state;
      if (i_flush) begin
         w_state_d = StEmpty;
      end else begin
         case (r_state)
            StEmpty: if (w_accept) w_state_d = StOne;
            StOne: begin
               if (w_accept && !w_drain) begin
                  w_state_d = StTwo;
               end else if (!w_accept && w_drain) begin
                  w_state_d = StEmpty;
               end
            end
            StTwo:   if (w_drain) w_state_d = StOne;
            default: w_state_d = StEmpty;
         endcase
      end
   end

   // Buffer FSM: outputs
   always_comb begin
      o_in_ready  = (r_state != StTwo);
      w_main_v    = (r_state != StEmpty);
      o_out_valid = w_main_v && !w_bubble;
   end

   // ---------------------------------------------------------------------------
   // Entry storage; an empty main entry is held at zero so data outputs read 0
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_main <= '0;
         r_skid <= '0;
      end else if (i_flush) begin
         r_main <= '0;
         r_skid <= '0;
      end else if (w_drain) begin
         if (r_state == StTwo) begin
            r_main <= r_skid;
            r_skid <= '0;
         end else begin
            r_main <= w_accept ? w_dec : '0;
         end
      end else begin
         if (w_bubble) begin
            r_main.load_use <= 1'b1;
         end
         if (w_accept) begin
            if (r_state == StEmpty) begin
               r_main <= w_dec;
            end else begin
               r_skid <= w_dec;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Load tracker: only an lw emitted in the directly preceding handshake counts
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ld_valid <= 1'b0;
         r_ld_dst   <= 5'd0;
      end else if (i_flush || !o_out_valid) begin
         r_ld_valid <= 1'b0;
      end else if (w_drain) begin
         r_ld_valid <= r_main.is_lw && r_main.dst_valid;
         r_ld_dst   <= r_main.dst;
      end
   end

   // ---------------------------------------------------------------------------
   // Output bundle
   // ---------------------------------------------------------------------------
   assign o_out_id         = r_main.id;
   assign o_out_rs         = r_main.rs;
   assign o_out_rt         = r_main.rt;
   assign o_out_rd         = r_main.rd;
   assign o_out_dst        = r_main.dst;
   assign o_out_dst_valid  = r_main.dst_valid;
   assign o_out_src1_valid = r_main.src1_valid;
   assign o_out_src2_valid = r_main.src2_valid;
   assign o_out_imm        = r_main.imm;
   assign o_out_illegal    = r_main.illegal;
   assign o_out_load_use   = HAZARD_STALL ? r_main.load_use : w_hit;

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, flow-controlled successor to the combinational instruction decoder. It accepts 32-bit instruction words over a valid/ready handshake and decodes opcode, register fields, destination/source qualifiers and an extended immediate. Results are held in a 2-entry skid buffer, and the block flags or stalls load-use hazards against the previously emitted instruction. It sits between instruction fetch and register read/execute.

## Interface
- ID_W, 6: width of `out_id`; must be ≥ 6.
- IMM_W, 32: width of `out_imm`; must be ≥ 26.
- HAZARD_STALL, 1: 1 inserts one bubble on load-use; 0 flags only.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; empties both entries and clears hazard tracking.
- in_valid  in  1  upstream holds valid instruction.
- in_ready  out  1  stage can accept; registered.
- in_ir  in  32  instruction word: opcode[31:26] rs[25:21] rt[20:16] rd[15:11] imm[15:0] target[25:0].
- out_valid  out  1  decoded instruction presented.
- out_ready  in  1  downstream accepts.
- out_id  out  ID_W  zero-extended opcode of a legal instruction; 0 if illegal.
- out_rs, out_rt, out_rd  out  5 each  raw register fields.
- out_dst  out  5  destination register index.
- out_dst_valid  out  1  instruction writes `out_dst`.
- out_src1_valid, out_src2_valid  out  1 each  rs and rt are read, respectively.
- out_imm  out  IMM_W  extended immediate or jump target.
- out_illegal  out  1  opcode not in the legal set.
- out_load_use  out  1  instruction depends on the immediately preceding lw.

## Operation
- Legal opcodes:
  - R-type: add 0, and 3, slt 19. dst = rd; src1 = rs; src2 = rt; imm = 0.
  - addi 1: dst = rt; src1 = rs; imm sign-extended.
  - ori 6: dst = rt; src1 = rs; imm zero-extended.
  - lw 8: dst = rt; src1 = rs; imm sign-extended.
  - sw 9: no dst; src1 = rs; src2 = rt; imm sign-extended.
  - j 16: no dst or srcs; imm = target[25:0] zero-extended.
- Any other opcode: out_illegal = 1; id, dst_valid, src valids and imm are all 0. Illegal instructions are still passed downstream, never dropped.
- A destination of register 0 forces out_dst_valid = 0.
- Decode happens combinationally on `in_ir`. The decoded bundle is registered into the main entry, or into the skid entry when main is occupied and not draining.
- Buffer states:
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without drain.
  - TWO → ONE on drain.
  - ONE → EMPTY on drain without accept.
  - Order is strictly FIFO.
- `in_ready` = skid entry empty, taken from the registered state.
- Hazard tracker: `ld_valid`, `ld_dst`.
  - Set on output handshake of lw with dst_valid.
  - Cleared on handshake of any other instruction, or in any cycle with `out_valid` = 0.
- hit = ld_valid && main valid && ((src1_valid && rs == ld_dst) || (src2_valid && rt == ld_dst)).
- HAZARD_STALL = 1: while hit, `out_valid` is forced to 0 (one bubble), which clears `ld_valid`. A sticky `load_use` bit is set in the main entry, and `out_load_use` is 1 when the instruction is presented next cycle.
- HAZARD_STALL = 0: `out_valid` is unaffected; `out_load_use` = hit, combinationally.

## Timing
- Reset or flush: both entries empty, `ld_valid` = 0, `out_valid` = 0, in_ready = 1. All data outputs are 0 and `out_load_use` is 0.
- Latency: an instruction accepted at edge N is presented with `out_valid` = 1 after edge N, unless a bubble is due.
- Throughput: one instruction per cycle with out_ready held at 1.
- Downstream stall: outputs stay stable while out_valid && !out_ready. Up to two instructions are absorbed; `in_ready` falls the cycle after the skid entry fills.
- Simultaneous accept and drain in state ONE: state stays ONE and main loads the new instruction.
- Flush concurrent with in_valid: flush wins and the instruction is not accepted.
- rst mid-operation: all contents and hazard state are discarded immediately.
- The bubble costs exactly one cycle regardless of `out_ready`. At most one bubble per lw.

## Test plan
- add $1,$3,$5 (0x00650800) then j 100 (0x40000064), out_ready = 1 → id 0, dst 1, src1/src2 valid; then id 16, imm 100, dst_valid 0; each 1 cycle after accept.
- addi $1,$2,-4 (imm 0xFFFC) and ori $1,$2,0xFFFC → imm 0xFFFFFFFC and 0x0000FFFC respectively; `sw` → dst_valid 0, src2_valid 1.
- Opcode 63 → out_illegal 1, id 0, passed through in order.
- Hold out_ready = 0 while streaming 3 instructions → first two held, in_ready 0 from the cycle after the second accept. Release → order preserved with no loss.
- lw $1,100($2) then add $4,$1,$3, HAZARD_STALL = 1 → one out_valid = 0 cycle, then add presented with out_load_use 1. With HAZARD_STALL = 0 → no bubble, out_load_use 1. lw $0 or an independent instruction → no hazard.
- Assert flush, and separately rst, with two entries held → out_valid 0 next cycle, in_ready 1, and a following dependent instruction shows no hazard.
